pedestrian_crossing_ctrl: RTL and testbench
===========================================

# pedestrian_crossing_ctrl

Pedestrian walk-signal stage that sits directly downstream of the vehicle traffic light controller. It consumes the controller's `red`, `yellow` and `green` lamp outputs and takes a raw push-button input. It synchronizes and debounces the button, latches the crossing request, and grants a WALK interval followed by a flashing DON'T WALK interval, always aligned to the start of a vehicle red phase. It also flags a sticky fault and forces DON'T WALK if the lamp inputs are ever not one-hot.

## Interface
- `DEBOUNCE_CYCLES`, default 3: consecutive synchronized-high cycles needed to accept a press; legal range 1..255.
- `WALK_TIME`, default 4: cycles of steady WALK; legal range 1..255.
- `FLASH_TIME`, default 2: cycles of flashing DON'T WALK; legal range 1..255.
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `red`  in  1  vehicle red lamp from the traffic light controller.
- `yellow`  in  1  vehicle yellow lamp.
- `green`  in  1  vehicle green lamp.
- `btn_in`  in  1  raw, asynchronous, bouncing pedestrian button; 1 = pressed.
- `walk`  out  1  WALK lamp.
- `dont_walk`  out  1  DON'T WALK lamp.
- `req_pending`  out  1  request latched and waiting for service ("wait" indicator).
- `fault`  out  1  sticky lamp-input fault.

## Operation
- **Synchronizer:** two flops, `btn_in` → `s1` → `s2`.
- **Debounce counter:** 8 bits.
  - Cleared while `s2`=0.
  - Increments while `s2`=1, saturating at DEBOUNCE_CYCLES.
  - A press event fires on the edge where the counter goes from DEBOUNCE_CYCLES-1 to DEBOUNCE_CYCLES with `s2`=1.
  - A held button therefore produces exactly one event; a new event requires `s2` to return to 0 first.
- **Pending flag:**
  - Set by a press event.
  - Cleared on entry to WALK.
  - If a press event and WALK entry occur on the same edge, the flag ends at 0.
  - Presses during WALK or FLASH set the flag, and that request is served at the next red phase.
  - `req_pending` equals the flag.
- **Red rising edge:** `red`=1 and `red_d`=0, where `red_d` is `red` registered. `red_d` resets to 1, so the red phase the controller shows right after reset never starts a walk.
- **FSM states:** IDLE, WALK, FLASH, FAULT. An 8-bit phase timer is cleared on every state change.
  - **IDLE:** `dont_walk`=1. On a red rising edge with (pending flag set, or press event this cycle) → WALK.
  - **WALK:** `walk`=1, `dont_walk`=0.
    - After WALK_TIME cycles in WALK → FLASH.
    - If `red` is sampled 0 → IDLE.
  - **FLASH:** `walk`=0. `dont_walk`=1 on the first FLASH cycle, then toggles every cycle.
    - After FLASH_TIME cycles → IDLE.
    - If `red` is sampled 0 → IDLE.
  - **FAULT:**
    - `walk`=0, `dont_walk`=1, `fault`=1.
    - Pending flag cleared; press events ignored.
    - Left only by `reset`.
- **Fault detect:** checked every non-reset cycle. When {`red`,`yellow`,`green`} is not 100, 010 or 001 → FAULT on that edge, from any state. Fault has priority over every other transition.
- **Safety gating:** `walk` output = `walk_q` AND `red` (combinational gate), so WALK is never lit while `red`=0, even in the cycle before the abort transition.
- Exactly one of `walk` or `dont_walk` is high in every state except the FLASH off-cycles and the gated-abort cycle.

## Timing
- **Reset values:** `walk`=0, `dont_walk`=1, `req_pending`=0, `fault`=0, state IDLE, counters 0, `s1`/`s2`=0, `red_d`=1.
- **Request latency:** `btn_in` held high from before edge k → `req_pending`=1 after edge k+1+DEBOUNCE_CYCLES (k+4 with defaults).
- **Walk entry:** red rises before edge m → `walk`=1 from edge m for WALK_TIME cycles. FLASH then runs for FLASH_TIME cycles, then IDLE. With defaults the total is 6 cycles, which fits the controller's 7-cycle red phase.
- **Abort:** `walk` drops combinationally the same cycle `red` falls; the state becomes IDLE on the next edge.
- **Reset mid-operation:** on the next edge, all outputs and state take their reset values and any pending request is lost.

## Test plan
- **Reset:** `reset`=1 for 2 cycles with `red`=1; release → `walk`=0, `dont_walk`=1, `req_pending`=0, `fault`=0. No WALK during the first red phase.
- **Debounce:**
  - `btn_in` high for 2 cycles, then low → `req_pending` stays 0.
  - `btn_in` high from edge k, held 20 cycles → `req_pending`=1 after edge k+4; exactly one request.
- **Full service:** `req_pending`=1, red rises before edge m →
  - `walk`=1 for edges m..m+3 and `req_pending`=0 after m;
  - `dont_walk` = 1,0 over the next 2 cycles;
  - then `dont_walk`=1 steady.
- **Abort:** `red` goes 0 during the second WALK cycle → `walk`=0 in that same cycle, `dont_walk`=1 from the next edge.
- **Press during WALK:** press event mid-WALK → `req_pending`=1 after WALK/FLASH ends, and WALK restarts at the next red rising edge.
- **Fault:** `red`=`green`=1 for one cycle → `fault`=1, `walk`=0, `dont_walk`=1 after that edge. These persist after the inputs return to one-hot and clear only on `reset`.

Source files
------------

// File: rtl/pedestrian_crossing_ctrl.sv
// pedestrian_crossing_ctrl: debounced pedestrian request served as WALK then flashing DON'T WALK at vehicle red onset
module pedestrian_crossing_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 3,
  parameter int unsigned WALK_TIME = 4,
  parameter int unsigned FLASH_TIME = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic red,
  input  logic yellow,
  input  logic green,
  input  logic btn_in,
  output logic walk,
  output logic dont_walk,
  output logic req_pending,
  output logic fault
);
  typedef enum logic [1:0] {IDLE, WALK, FLASH, FAULT} state_e;
  state_e state_q, state_d;
  logic s1_q, s2_q, red_q, pend_q, pend_d;
  logic [7:0] deb_q, deb_d, tmr_q, tmr_d;
  logic press, red_rise, lamp_ok;
  assign press = s2_q && deb_q == 8'(DEBOUNCE_CYCLES - 1);
  assign red_rise = red && !red_q;
  assign lamp_ok = (red ^ yellow ^ green) && !(red && yellow && green);
  assign deb_d = !s2_q ? 8'd0 : deb_q == 8'(DEBOUNCE_CYCLES) ? deb_q : deb_q + 8'd1;
  assign pend_d = (state_d == FAULT || (state_d == WALK && state_q != WALK)) ? 1'b0 : pend_q || press;
  assign tmr_d = state_d != state_q ? 8'd0 : tmr_q == 8'hFF ? tmr_q : tmr_q + 8'd1;
  assign walk = state_q == WALK && red;
  assign dont_walk = state_q == FLASH ? !tmr_q[0] : state_q != WALK;
  assign req_pending = pend_q;
  assign fault = state_q == FAULT;
  // next state: lamp fault first, then walk entry at red onset, timed exits and red-loss aborts
  always_comb begin
    state_d = state_q;
    if (!lamp_ok) state_d = FAULT;
    else case (state_q)
      IDLE:    state_d = (red_rise && (pend_q || press)) ? WALK : IDLE;
      WALK:    state_d = !red ? IDLE : tmr_q == 8'(WALK_TIME - 1) ? FLASH : WALK;
      FLASH:   state_d = (!red || tmr_q == 8'(FLASH_TIME - 1)) ? IDLE : FLASH;
      default: state_d = FAULT;
    endcase
  end
  // registers: button synchronizer, debounce, request flag, red edge history, phase timer, state
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      deb_q <= 8'd0;
      pend_q <= 1'b0;
      red_q <= 1'b1;
      tmr_q <= 8'd0;
      state_q <= IDLE;
    end else begin
      s1_q <= btn_in;
      s2_q <= s1_q;
      deb_q <= deb_d;
      pend_q <= pend_d;
      red_q <= red;
      tmr_q <= tmr_d;
      state_q <= state_d;
    end
  end
endmodule

// File: tb/tb_pedestrian_crossing_ctrl.sv
// tb_pedestrian_crossing_ctrl: randomized traffic and button stimulus against a service-age reference model
module tb_pedestrian_crossing_ctrl;
  localparam int DEB = 3, WT = 4, FT = 2;
  logic clock = 0, reset = 1, red = 1, yellow = 0, green = 0, btn_in = 0;
  logic walk, dont_walk, req_pending, fault;
  int compared = 0, mismatched = 0, walks = 0;
  logic [3:0] exp_q[$];
  bit m_valid = 0, m_s1, m_s2, m_pend, m_fault, m_red_prev;
  int m_run, m_age;
  int col, left, bleft;
  bit bval;
  pedestrian_crossing_ctrl #(.DEBOUNCE_CYCLES(DEB), .WALK_TIME(WT), .FLASH_TIME(FT)) dut (
    .clock(clock), .reset(reset), .red(red), .yellow(yellow), .green(green), .btn_in(btn_in),
    .walk(walk), .dont_walk(dont_walk), .req_pending(req_pending), .fault(fault)
  );
  always #5 clock = ~clock;
  task automatic model_edge();
    bit press, start;
    if (reset) begin
      m_s1 = 0; m_s2 = 0; m_pend = 0; m_fault = 0; m_red_prev = 1; m_run = 0; m_age = -1; m_valid = 1;
      return;
    end
    if (!m_valid) return;
    m_run = m_s2 ? m_run + 1 : 0;
    press = m_s2 && m_run == DEB;
    start = 0;
    if (m_fault || (int'(red) + int'(yellow) + int'(green)) != 1) begin
      m_fault = 1; m_pend = 0; m_age = -1;
    end else begin
      if (m_age >= 0) m_age = (!red || m_age + 1 >= WT + FT) ? -1 : m_age + 1;
      else if (red && !m_red_prev && (m_pend || press)) begin
        m_age = 0; start = 1; walks++;
      end
      m_pend = !start && (m_pend || press);
    end
    m_red_prev = red;
    m_s2 = m_s1;
    m_s1 = btn_in;
  endtask
  function automatic logic [3:0] expect_now();
    bit w, dw;
    w = m_age >= 0 && m_age < WT && red;
    dw = m_age < 0 || (m_age >= WT && (m_age - WT) % 2 == 0);
    return {w, dw, m_pend, m_fault};
  endfunction
  task automatic cyc(input bit r, input bit y, input bit g, input bit b, input bit rs);
    red = r; yellow = y; green = g; btn_in = b; reset = rs;
    if (m_valid) exp_q.push_back(expect_now());
    @(posedge clock);
    model_edge();
    #1;
  endtask
  task automatic chk(input string n, input logic a, input logic e);
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL %s: got %b expected %b at %0t", n, a, e, $time);
    end
  endtask
  always @(negedge clock) begin
    logic [3:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("walk", walk, e[3]);
      chk("dont_walk", dont_walk, e[2]);
      chk("req_pending", req_pending, e[1]);
      chk("fault", fault, e[0]);
    end
  end
  task automatic run(input int n, input bit inject);
    logic [2:0] bad [5];
    bit r, y, g;
    bad = '{3'b000, 3'b110, 3'b011, 3'b101, 3'b111};
    for (int i = 0; i < n; i++) begin
      if (left == 0) begin
        col = (col + 1) % 3;
        left = col == 0 ? int'($urandom_range(3, 6)) : col == 1 ? int'($urandom_range(1, 2)) : int'($urandom_range(2, 9));
      end
      left--;
      if (bleft == 0) begin
        bval = !bval;
        bleft = bval ? int'($urandom_range(1, 12)) : int'($urandom_range(2, 25));
      end
      bleft--;
      r = col == 2; y = col == 1; g = col == 0;
      if (inject && i == n / 2) {r, y, g} = bad[$urandom_range(0, 4)];
      cyc(r, y, g, bval, 0);
    end
  endtask
  initial begin
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 1);
      col = 2; left = 7; bval = 0; bleft = int'($urandom_range(1, 5));
      run(500, 0);
      if (k < 2) run(40, 1);
    end
    repeat (3) cyc(1, 0, 0, 0, 0);
    repeat (2) @(negedge clock);
    compared++;
    if (walks == 0 || exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL activity: walks %0d pending %0d, required walks>0 and pending 0", walks, exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
